// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM state type shared by the ALU pipeline.
package alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_NEG  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_MULS = 4'b1001;
    localparam logic [3:0] OP_SLLV = 4'b1100;
    localparam logic [3:0] OP_SRLV = 4'b1101;
    localparam logic [3:0] OP_SRAV = 4'b1110;
    localparam int CARRY = 2;
    localparam int NEG   = 1;
    localparam int ZERO  = 0;
    typedef enum logic {IDLE, MULT} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: radix-2 shift-add multiplier on operand magnitudes, one iteration per cycle.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic [2*WIDTH-1:0] acc, mcand, acc_in, mc_in;
    logic [WIDTH-1:0] mplier, mp_in, mag_a, mag_b;
    logic [CW-1:0] cnt;
    logic neg;
    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
    assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
    // the first iteration runs on the start edge straight from the inputs
    assign acc_in = start ? '0 : acc;
    assign mc_in = start ? {{WIDTH{1'b0}}, mag_a} : mcand;
    assign mp_in = start ? mag_b : mplier;
    assign done = busy && cnt == CW'(WIDTH);
    assign product = neg ? -acc : acc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
            busy <= 1'b0;
            neg <= 1'b0;
        end else if (start || (busy && !done)) begin
            acc <= acc_in + (mp_in[0] ? mc_in : '0);
            mcand <= mc_in << 1;
            mplier <= mp_in >> 1;
            cnt <= start ? CW'(1) : cnt + CW'(1);
            busy <= 1'b1;
            neg <= start ? (is_signed && (a[WIDTH-1] ^ b[WIDTH-1])) : neg;
        end else if (done) begin
            busy <= 1'b0;
            cnt <= '0;
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with registered result, single-cycle ops inline and iterative multiply.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [2:0]       flags
);
    state_t state, next_state;
    logic accept, is_mul, start, mul_busy, mul_done, carry;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0] sum;
    logic [SHW-1:0] sa;
    logic [2*WIDTH-1:0] prod;
    assign in_ready = state == IDLE && !mul_busy && (!out_valid || out_ready);
    assign accept = in_valid && in_ready;
    assign is_mul = control == OP_MULU || control == OP_MULS;
    assign start = accept && is_mul;
    assign sa = control[3] ? input2[SHW-1:0] : shamt;
    always_comb begin
        sum = '0;
        res = '0;
        carry = 1'b0;
        case (control)
            OP_ADD: begin
                sum = {1'b0, input1} + {1'b0, input2};
                res = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_NEG: begin
                sum = {1'b0, ~input2} + (WIDTH+1)'(1);
                res = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_AND: res = input1 & input2;
            OP_XOR: res = input1 ^ input2;
            OP_SLL, OP_SLLV: res = input1 << sa;
            OP_SRL, OP_SRLV: res = input1 >> sa;
            OP_SRA, OP_SRAV: res = WIDTH'($signed(input1) >>> sa);
            OP_SLT: res = WIDTH'($signed(input1) < $signed(input2));
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        next_state = (state == IDLE && start) ? MULT : (state == MULT && mul_done) ? IDLE : state;
    end
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk(clk),
        .rst(rst),
        .start(start),
        .is_signed(control == OP_MULS),
        .a(input1),
        .b(input2),
        .busy(mul_busy),
        .done(mul_done),
        .product(prod)
    );
    // result register: multiply completion has priority, reserved opcodes fall through as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out <= '0;
            hi <= '0;
            flags <= '0;
        end else if (state == MULT && mul_done) begin
            out_valid <= 1'b1;
            out <= prod[WIDTH-1:0];
            hi <= prod[2*WIDTH-1:WIDTH];
            flags[CARRY] <= 1'b0;
            flags[NEG] <= prod[2*WIDTH-1];
            flags[ZERO] <= prod == '0;
        end else if (accept && !is_mul) begin
            out_valid <= 1'b1;
            out <= res;
            hi <= '0;
            flags[CARRY] <= carry;
            flags[NEG] <= res[WIDTH-1];
            flags[ZERO] <= res == '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid;
    logic [31:0] input1 = '0, input2 = '0, out, hi;
    logic [4:0] shamt = '0;
    logic [3:0] control = '0;
    logic [2:0] flags;
    int errors = 0;
    int checks = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .input1(input1), .input2(input2), .shamt(shamt), .control(control),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .hi(hi), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // returns {flags, hi, out}
    function automatic logic [66:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
        logic [63:0] p;
        logic [31:0] r;
        logic c;
        logic [4:0] s;
        s = op[3] ? b[4:0] : sh;
        p = '0;
        r = '0;
        c = 1'b0;
        case (op)
            4'd0: begin p = {32'b0, a} + {32'b0, b}; r = p[31:0]; c = p[32]; end
            4'd1: begin r = 32'd0 - b; c = (b == 0); end
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4, 4'd12: r = a << s;
            4'd5, 4'd13: r = a >> s;
            4'd6, 4'd14: r = $signed(a) >>> s;
            4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: p = {32'b0, a} * {32'b0, b};
            4'd9: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            default: ;
        endcase
        if (op == 4'd8 || op == 4'd9) return {1'b0, p[63], p == 64'd0, p};
        return {c, r[31], r == 32'd0, 32'd0, r};
    endfunction

    task automatic run_op(string tag, logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
        logic [66:0] e;
        int n;
        e = model(op, a, b, sh);
        @(negedge clk);
        control = op;
        input1 = a;
        input2 = b;
        shamt = sh;
        in_valid = 1'b1;
        check({tag, ".rdy"}, in_ready, 1);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
        end while (!out_valid && n < 100);
        check({tag, ".lat"}, n, (op == 4'd8 || op == 4'd9) ? 33 : 1);
        check({tag, ".out"}, out, e[31:0]);
        check({tag, ".hi"}, hi, e[63:32]);
        check({tag, ".flags"}, flags, e[66:64]);
    endtask

    initial begin
        logic [31:0] ra, rb, exp_q[$];
        logic [3:0] rop;
        #12;
        check("rst.valid", out_valid, 0);
        check("rst.out", out, 0);
        check("rst.hi", hi, 0);
        check("rst.flags", flags, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_ovf", 4'd0, 32'h7FFFFFFF, 32'd106, 5'd0);
        check("add_ovf.lit", {flags, out}, {3'b010, 32'h80000069});
        run_op("add_carry", 4'd0, 32'h80000000, 32'h80000000, 5'd0);
        check("add_carry.lit", {flags, out}, {3'b101, 32'h0});
        run_op("neg0", 4'd1, 32'd5, 32'd0, 5'd0);
        check("neg0.lit", {flags, out}, {3'b101, 32'h0});
        run_op("neg", 4'd1, 32'd0, 32'd896989867, 5'd0);
        check("neg.lit", {flags, out}, {3'b010, -32'sd896989867});
        run_op("sll", 4'd4, 32'd259, 32'd0, 5'd4);
        check("sll.lit", out, 32'd4144);
        run_op("srav", 4'd14, -32'sd259, 32'd31, 5'd0);
        check("srav.lit", {flags, out}, {3'b010, 32'hFFFFFFFF});
        run_op("slt", 4'd7, -32'sd22, 32'd0, 5'd0);
        check("slt.lit", out, 32'd1);
        run_op("muls", 4'd9, -32'sd7, 32'd6, 5'd0);
        check("muls.lit", {flags, hi, out}, {3'b010, 32'hFFFFFFFF, 32'hFFFFFFD6});
        run_op("mulu", 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        check("mulu.lit", {hi, out}, {32'hFFFFFFFE, 32'h1});
        run_op("muls_min", 4'd9, 32'h80000000, 32'h80000000, 5'd0);
        run_op("muls_min2", 4'd9, 32'h80000000, 32'd1, 5'd0);
        run_op("rsv", 4'd15, 32'd9, 32'd9, 5'd3);
        check("rsv.lit", {flags, hi, out}, {3'b001, 64'd0});

        // backpressure: result must hold while the consumer stalls
        @(negedge clk);
        out_ready = 1'b0;
        control = 4'd0;
        input1 = 32'd105;
        input2 = 32'd106;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.valid", out_valid, 1);
        check("bp.out", out, 32'd211);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            control = 4'd3;
            in_valid = 1'b1;
            check("bp.hold", out, 32'd211);
            check("bp.rdy", in_ready, 0);
        end
        in_valid = 1'b0;
        check("bp.valid2", out_valid, 1);

        // back-to-back, one result per cycle
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            rb = $urandom;
            exp_q.push_back(ra ^ rb);
            control = 4'd3;
            input1 = ra;
            input2 = rb;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("b2b.valid", out_valid, 1);
            check("b2b.out", out, exp_q.pop_front());
        end
        in_valid = 1'b0;

        // reset in the middle of a multiply
        @(negedge clk);
        control = 4'd9;
        input1 = -32'sd7;
        input2 = 32'd6;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mrst.valid", out_valid, 0);
        check("mrst.outs", {flags, hi, out}, 67'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("mrst.rdy", in_ready, 1);
        repeat (40) begin
            @(negedge clk);
            check("mrst.novalid", out_valid, 0);
        end
        run_op("mrst.add", 4'd0, 32'd1000, 32'd234, 5'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            run_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
